// File: rtl/rv_trace_pkg.sv
// rv_trace_pkg: shared types and constants for the retire trace buffer
package rv_trace_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2,
    ST_DRAIN   = 2'd3
  } trace_state_t;
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
    logic [31:0] rd_data;
  } trace_rec_t;
  localparam logic [1:0] BEAT_PC    = 2'd0;
  localparam logic [1:0] BEAT_INSTR = 2'd1;
  localparam logic [1:0] BEAT_DATA  = 2'd2;
endpackage

// File: rtl/rv_trace_ram.sv
// rv_trace_ram: DEPTH x trace_rec_t storage, one write port, combinational read
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr -> o_rdata read port.
module rv_trace_ram
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  trace_rec_t               i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output trace_rec_t               o_rdata
);
  trace_rec_t mem_q [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/rv_trace_buf.sv
// rv_trace_buf: circular retire-trace capture buffer drained as 3-beat records
// Ports: i_clk/i_reset (sync, active high); i_retire_* retire record input;
//   i_arm/i_stop/i_wrap capture control; o_rd_data/o_rd_valid/i_rd_ready drain
//   stream; o_count records held; o_state FSM state; o_overflow record lost.
// Optional: TRACE_TRIGGER_EN adds i_trig_en/i_trig_pc to freeze on a PC match.
module rv_trace_buf
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_retire_valid,
  input  logic [29:0]              i_retire_pc,
  input  logic [31:0]              i_retire_instr,
  input  logic [31:0]              i_retire_rd_data,
  input  logic                     i_arm,
  input  logic                     i_stop,
  input  logic                     i_wrap,
`ifdef TRACE_TRIGGER_EN
  input  logic                     i_trig_en,
  input  logic [29:0]              i_trig_pc,
`endif
  output logic [31:0]              o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [1:0]               o_state,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  trace_state_t  state_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [1:0]    beat_q;
  logic          overflow_q;
  logic          full, we, trig;
  trace_rec_t    wrec, rrec;
  assign full = count_q == CW'(DEPTH);
  // a full buffer still accepts the retire when wrapping: it replaces the oldest
  assign we   = state_q == ST_CAPTURE && i_retire_valid && (!full || i_wrap);
`ifdef TRACE_TRIGGER_EN
  assign trig = i_trig_en && i_retire_pc == i_trig_pc;
`else
  assign trig = 1'b0;
`endif
  assign wrec = '{pc: i_retire_pc, instr: i_retire_instr, rd_data: i_retire_rd_data};
  rv_trace_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk  (i_clk),
    .i_we   (we),
    .i_waddr(wr_q),
    .i_wdata(wrec),
    .i_raddr(rd_q),
    .o_rdata(rrec)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      beat_q     <= BEAT_PC;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_arm) begin
          state_q    <= ST_CAPTURE;
          wr_q       <= '0;
          rd_q       <= '0;
          count_q    <= '0;
          overflow_q <= 1'b0;
        end
        ST_CAPTURE: begin
          if (we) wr_q <= wr_q + AW'(1);
          if (we && full) rd_q <= rd_q + AW'(1);
          if (we && !full) count_q <= count_q + CW'(1);
          if (i_retire_valid && full) overflow_q <= 1'b1;
          if (i_stop || (i_retire_valid && full && !i_wrap) || (we && trig)) state_q <= ST_FROZEN;
        end
        ST_FROZEN: begin
          state_q <= count_q != '0 ? ST_DRAIN : ST_IDLE;
          beat_q  <= BEAT_PC;
        end
        ST_DRAIN: if (i_rd_ready) begin
          beat_q <= beat_q == BEAT_DATA ? BEAT_PC : beat_q + 2'd1;
          if (beat_q == BEAT_DATA) begin
            rd_q    <= rd_q + AW'(1);
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end
  assign o_rd_valid = state_q == ST_DRAIN;
  assign o_rd_data  = !o_rd_valid ? 32'd0 :
                      beat_q == BEAT_PC    ? {rrec.pc, 2'b00} :
                      beat_q == BEAT_INSTR ? rrec.instr : rrec.rd_data;
  assign o_count    = count_q;
  assign o_state    = state_q;
  assign o_overflow = overflow_q;
endmodule

// File: tb/tb_rv_trace_buf.sv
// tb_rv_trace_buf: randomized self-checking bench with a queue-based trace model
module tb_rv_trace_buf;
  import rv_trace_pkg::*;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          retire_valid = 1'b0;
  logic [29:0]   retire_pc = '0;
  logic [31:0]   retire_instr = '0, retire_rd_data = '0;
  logic          arm = 1'b0, stop = 1'b0, wrap = 1'b0, rd_ready = 1'b0;
  logic          trig_en = 1'b0;
  logic [29:0]   trig_pc = '0;
  logic [31:0]   rd_data;
  logic          rd_valid, overflow;
  logic [CW-1:0] count;
  logic [1:0]    state;
  int            n_chk = 0, n_pass = 0;
  trace_rec_t    model_q[$];
  logic          m_ovf = 1'b0, m_frozen = 1'b0;

  rv_trace_buf #(.DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_retire_valid  (retire_valid),
    .i_retire_pc     (retire_pc),
    .i_retire_instr  (retire_instr),
    .i_retire_rd_data(retire_rd_data),
    .i_arm           (arm),
    .i_stop          (stop),
    .i_wrap          (wrap),
`ifdef TRACE_TRIGGER_EN
    .i_trig_en       (trig_en),
    .i_trig_pc       (trig_pc),
`endif
    .o_rd_data       (rd_data),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_count         (count),
    .o_state         (state),
    .o_overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_chk++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_chk++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else n_pass++;
    n_chk++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_frozen = 1'b0;
    n_chk++; if (state !== 2'd1) $display("FAIL arm_state got %0d want 1", state); else n_pass++;
    n_chk++; if (count !== '0 || overflow !== 1'b0) $display("FAIL arm_clear count %0d ovf %b want 0 0", count, overflow); else n_pass++;
  endtask

  // one retire in CAPTURE, optionally with stop; model applies the keep/drop/overwrite rules
  task automatic retire(input logic [29:0] pc, input logic with_stop);
    trace_rec_t r;
    logic stored;
    r.pc = pc;
    r.instr = $urandom;
    r.rd_data = $urandom;
    retire_valid = 1'b1;
    retire_pc = r.pc;
    retire_instr = r.instr;
    retire_rd_data = r.rd_data;
    stop = with_stop;
    step();
    retire_valid = 1'b0;
    stop = 1'b0;
    stored = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(r);
    else if (wrap) begin
      void'(model_q.pop_front());
      model_q.push_back(r);
      m_ovf = 1'b1;
    end else begin
      m_ovf = 1'b1;
      m_frozen = 1'b1;
      stored = 1'b0;
    end
    if (with_stop) m_frozen = 1'b1;
`ifdef TRACE_TRIGGER_EN
    if (stored && trig_en && pc == trig_pc) m_frozen = 1'b1;
`endif
    n_chk++; if (count !== CW'(model_q.size())) $display("FAIL retire_count got %0d want %0d", count, model_q.size()); else n_pass++;
    n_chk++; if (overflow !== m_ovf) $display("FAIL retire_overflow got %b want %b", overflow, m_ovf); else n_pass++;
    n_chk++; if (state !== (m_frozen ? 2'd2 : 2'd1)) $display("FAIL retire_state got %0d want %0d", state, m_frozen ? 2 : 1); else n_pass++;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    m_frozen = 1'b1;
    n_chk++; if (state !== 2'd2) $display("FAIL stop_state got %0d want 2", state); else n_pass++;
  endtask

  // FROZEN -> DRAIN/IDLE, then consume every beat; noise=1 drives ignored controls
  task automatic drain(input int mode, input logic noise);
    trace_rec_t r;
    logic [31:0] exp;
    logic rdy = 1'b0;
    int cyc = 0;
    if (noise) begin
      retire_valid = 1'b1;
      arm = 1'b1;
      stop = 1'b1;
    end
    step();
    n_chk++; if (state !== (model_q.size() > 0 ? 2'd3 : 2'd0)) $display("FAIL frozen_exit got %0d want %0d", state, model_q.size() > 0 ? 3 : 0); else n_pass++;
    while (model_q.size() > 0 && cyc < 2000) begin
      r = model_q[0];
      n_chk++; if (count !== CW'(model_q.size())) $display("FAIL drain_count got %0d want %0d", count, model_q.size()); else n_pass++;
      for (int b = 0; b < 3; b++) begin
        exp = b == 0 ? {r.pc, 2'b00} : b == 1 ? r.instr : r.rd_data;
        do begin
          rdy = mode == 0 ? 1'b1 : mode == 1 ? ~rdy : 1'($urandom_range(0, 1));
          if (noise) begin
            retire_valid = 1'($urandom_range(0, 1));
            retire_pc = $urandom;
            arm = 1'($urandom_range(0, 1));
            stop = 1'($urandom_range(0, 1));
          end
          n_chk++;
          if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL drain_beat%0d valid %b data %h want 1 %h", b, rd_valid, rd_data, exp);
          else n_pass++;
          rd_ready = rdy;
          step();
          cyc++;
        end while (!rdy && cyc < 2000);
      end
      void'(model_q.pop_front());
    end
    rd_ready = 1'b0;
    retire_valid = 1'b0;
    arm = 1'b0;
    stop = 1'b0;
    n_chk++; if (cyc >= 2000) $display("FAIL drain_timeout cycles %0d limit 2000", cyc); else n_pass++;
    n_chk++; if (state !== 2'd0 || count !== '0) $display("FAIL drain_end state %0d count %0d want 0 0", state, count); else n_pass++;
    n_chk++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) $display("FAIL drain_idle_out valid %b data %h want 0 0", rd_valid, rd_data); else n_pass++;
  endtask

  task automatic test_basic();
    wrap = 1'b0;
    do_arm();
    for (int i = 0; i < 3; i++) retire(30'((32'h100 + 4 * i) >> 2), 1'b0);
    do_stop();
    drain(0, 1'b0);
  endtask

  task automatic test_wrap();
    wrap = 1'b1;
    do_arm();
    for (int i = 0; i < 20; i++) retire(30'((32'h1000 + 4 * i) >> 2), 1'b0);
    n_chk++; if (count !== CW'(16) || overflow !== 1'b1) $display("FAIL wrap_full count %0d ovf %b want 16 1", count, overflow); else n_pass++;
    do_stop();
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL frozen_rd_valid got %b want 0", rd_valid); else n_pass++;
    drain(2, 1'b0);
  endtask

  task automatic test_nowrap();
    wrap = 1'b0;
    do_arm();
    for (int i = 0; i < 17; i++) retire(30'((32'h2000 + 4 * i) >> 2), 1'b0);
    n_chk++; if (state !== 2'd2 || count !== CW'(16) || overflow !== 1'b1) $display("FAIL nowrap_full state %0d count %0d ovf %b want 2 16 1", state, count, overflow); else n_pass++;
    drain(1, 1'b1);
  endtask

  task automatic test_stop_with_retire();
    wrap = 1'b0;
    do_arm();
    retire(30'($urandom), 1'b0);
    retire(30'($urandom), 1'b1);
    drain(1, 1'b0);
  endtask

  task automatic test_idle_ignored();
    retire_valid = 1'b1;
    stop = 1'b1;
    step();
    retire_valid = 1'b0;
    stop = 1'b0;
    n_chk++; if (state !== 2'd0 || count !== '0) $display("FAIL idle_ignore state %0d count %0d want 0 0", state, count); else n_pass++;
    do_arm();
    do_stop();
    drain(0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    wrap = 1'b0;
    do_arm();
    retire(30'($urandom), 1'b0);
    retire(30'($urandom), 1'b0);
    do_stop();
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    n_chk++; if (state !== 2'd3 || rd_data !== model_q[0].instr) $display("FAIL pre_reset_beat1 state %0d data %h want 3 %h", state, rd_data, model_q[0].instr); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_q.delete();
    n_chk++; if (state !== 2'd0 || rd_valid !== 1'b0 || count !== '0) $display("FAIL mid_drain_reset state %0d valid %b count %0d want 0 0 0", state, rd_valid, count); else n_pass++;
    n_chk++; if (rd_data !== 32'd0 || overflow !== 1'b0) $display("FAIL mid_drain_reset_out data %h ovf %b want 0 0", rd_data, overflow); else n_pass++;
    do_arm();
    retire(30'($urandom), 1'b0);
    do_stop();
    drain(0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      wrap = 1'($urandom_range(0, 1));
      do_arm();
      for (int n = $urandom_range(0, 24); n > 0 && !m_frozen; n--) begin
        if ($urandom_range(0, 3) == 0) step();
        retire(30'($urandom), 1'($urandom_range(0, 15) == 0));
      end
      if (!m_frozen) do_stop();
      drain(2, 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef TRACE_TRIGGER_EN
  task automatic test_trigger();
    wrap = 1'b0;
    trig_en = 1'b1;
    trig_pc = 30'(32'h104 >> 2);
    do_arm();
    for (int i = 0; i < 4 && !m_frozen; i++) retire(30'((32'h100 + 4 * i) >> 2), 1'b0);
    n_chk++; if (state !== 2'd2 || count !== CW'(2)) $display("FAIL trigger_freeze state %0d count %0d want 2 2", state, count); else n_pass++;
    trig_en = 1'b0;
    drain(0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_nowrap();
    test_stop_with_retire();
    test_idle_ignored();
    test_reset_mid_drain();
`ifdef TRACE_TRIGGER_EN
    test_trigger();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
